pc_sequencer: RTL

- Next-PC controller for the IF stage of the MUSA core.
- Owns the fetch address register and selects the next fetch address from these sources: sequential, branch, jump, halt/resume and interrupt vector.
- Generates the PC write-enable, a one-cycle pipeline flush after every redirect, and a boot hold-off after reset.
- Sits between the EX/ID control outputs and instruction memory; it sequences the PC rather than storing it passively.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the EX/ID stage and the IF next-PC sequencer.
// The master side (pipeline control) drives the requests; the slave side
// (pc_sequencer) returns the fetch address and the pipeline control outputs.
interface pc_sequencer_if #(
    parameter int PC_W = 13
);
    logic            stall_i;
    logic            branch_taken_i;
    logic [PC_W-1:0] branch_target_i;
    logic            jump_i;
    logic [PC_W-1:0] jump_target_i;
    logic            halt_i;
    logic            resume_i;
    logic            irq_i;
    logic            eret_i;
    logic [PC_W-1:0] pc_o;
    logic [PC_W-1:0] pc_next_o;
    logic            pc_write_o;
    logic            flush_o;
    logic            halted_o;
    logic            irq_ack_o;
    logic [PC_W-1:0] epc_o;

    modport master (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
               halt_i, resume_i, irq_i, eret_i,
        input  pc_o, pc_next_o, pc_write_o, flush_o, halted_o, irq_ack_o, epc_o
    );

    modport slave (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
               halt_i, resume_i, irq_i, eret_i,
        output pc_o, pc_next_o, pc_write_o, flush_o, halted_o, irq_ack_o, epc_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the MUSA IF stage.
// Owns the fetch address register, chooses the next fetch address
// (sequential / branch / jump / eret / irq vector), raises a one-cycle flush
// after every redirect and holds the PC at RESET_VECTOR for BOOT_CYCLES after
// reset. Interrupt vectoring and eret are compiled in only when the macro
// PCSEQ_IRQ_EN is defined; otherwise irq_i/eret_i are ignored and
// irq_ack_o/epc_o read as zero.
module pc_sequencer #(
    parameter int              PC_W         = 13,
    parameter logic [PC_W-1:0] RESET_VECTOR = {PC_W{1'b0}},
    parameter logic [PC_W-1:0] IRQ_VECTOR   = PC_W'(13'h0100),
    parameter int              BOOT_CYCLES  = 2
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(BOOT_CYCLES + 1) + 1;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [PC_W-1:0] pc_q;
    logic            flush_q;
    logic            halted_q;
    logic [PC_W-1:0] pc_next_s;
    logic            pc_write_s;
    logic            redirect_s;
    logic            take_irq_s;
    logic            take_eret_s;
    logic            irq_ok_s;
    logic            eret_ok_s;
    logic            boot_last_s;
    logic [PC_W-1:0] epc_s;

    // Boot ends on the edge that completes BOOT_CYCLES cycles (or the first edge if zero).
    assign boot_last_s = ((32'(boot_cnt_q) + 32'd1) >= 32'(BOOT_CYCLES));

`ifdef PCSEQ_IRQ_EN
    logic            in_handler_q;
    logic            irq_ack_q;
    logic [PC_W-1:0] epc_q;

    assign irq_ok_s  = bus.irq_i & ~in_handler_q;
    assign eret_ok_s = bus.eret_i;
    assign epc_s     = epc_q;

    // Interrupt bookkeeping: save return PC, track handler entry/exit, pulse ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_handler_q <= 1'b0;
            irq_ack_q    <= 1'b0;
            epc_q        <= {PC_W{1'b0}};
        end else begin
            irq_ack_q <= take_irq_s;
            if (take_irq_s) begin
                epc_q        <= pc_q;
                in_handler_q <= 1'b1;
            end else if (take_eret_s) begin
                in_handler_q <= 1'b0;
            end
        end
    end

    assign bus.irq_ack_o = irq_ack_q;
    assign bus.epc_o     = epc_q;
`else
    logic unused_irq_s;

    assign irq_ok_s      = 1'b0;
    assign eret_ok_s     = 1'b0;
    assign epc_s         = {PC_W{1'b0}};
    assign unused_irq_s  = bus.irq_i ^ bus.eret_i;
    assign bus.irq_ack_o = 1'b0;
    assign bus.epc_o     = {PC_W{1'b0}};
`endif

    // Next-PC selection, write enable and next state by redirect priority.
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pc_next_s   = pc_q;
        pc_write_s  = 1'b0;
        redirect_s  = 1'b0;
        take_irq_s  = 1'b0;
        take_eret_s = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (boot_last_s) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN, ST_FLUSH: begin
                if (irq_ok_s) begin
                    take_irq_s = 1'b1;
                    redirect_s = 1'b1;
                    pc_next_s  = IRQ_VECTOR;
                end else if (bus.jump_i) begin
                    redirect_s = 1'b1;
                    pc_next_s  = bus.jump_target_i;
                end else if (bus.branch_taken_i) begin
                    redirect_s = 1'b1;
                    pc_next_s  = bus.branch_target_i;
                end else if (eret_ok_s) begin
                    take_eret_s = 1'b1;
                    redirect_s  = 1'b1;
                    pc_next_s   = epc_s;
                end else if (bus.halt_i) begin
                    state_d = ST_HALT;
                end else if (bus.stall_i) begin
                    state_d = ST_RUN;
                end else begin
                    pc_next_s  = pc_q + PC_W'(1);
                    pc_write_s = 1'b1;
                    state_d    = ST_RUN;
                end
                if (redirect_s) begin
                    pc_write_s = 1'b1;
                    state_d    = ST_FLUSH;
                end else begin
                    pc_write_s = pc_write_s;
                end
            end
            ST_HALT: begin
                if (irq_ok_s) begin
                    take_irq_s = 1'b1;
                    redirect_s = 1'b1;
                    pc_next_s  = IRQ_VECTOR;
                    pc_write_s = 1'b1;
                    state_d    = ST_FLUSH;
                end else if (bus.resume_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Core sequencer state: FSM, boot counter, PC register and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= {CNT_W{1'b0}};
            pc_q       <= RESET_VECTOR;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            flush_q    <= redirect_s;
            halted_q   <= (state_d == ST_HALT);
            if (pc_write_s) begin
                pc_q <= pc_next_s;
            end
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_next_o  = pc_next_s;
    assign bus.pc_write_o = pc_write_s;
    assign bus.flush_o    = flush_q;
    assign bus.halted_o   = halted_q;
endmodule
